fsk_zc_demod: RTL and testbench

Parametrised zero-crossing FSK demodulator that replaces the fixed-window, fixed-threshold demodulator in the FSK receive path. It sits between the ADC sample stream, or the on-chip GFSK modulator loopback, and the bit-level framer. It applies a runtime-configurable Schmitt trigger around a programmable centre level and counts crossings over a programmable samples-per-bit window. It emits one decided bit per window with a valid strobe, the raw crossing count, and a saturation flag.

---
 rtl/fsk_zc_demod.sv | 106 ++++++++++
 tb/tb_fsk_zc_demod.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fsk_zc_demod.sv
// fsk_zc_demod: zero-crossing FSK demodulator with a runtime Schmitt trigger and a per-bit crossing window.
// Emits one decided bit per window, plus the raw crossing count and a counter saturation flag.
module fsk_zc_demod #(
  parameter int DATA_W = 8,
  parameter int WIN_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_sample_in,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_cfg_center,
  input  logic [DATA_W-1:0] i_cfg_hyst,
  input  logic [WIN_W-1:0]  i_cfg_window,
  input  logic [CNT_W-1:0]  i_cfg_decide,
  input  logic              i_sync,
  output logic              o_bit_out,
  output logic              o_bit_valid,
  output logic [CNT_W-1:0]  o_cross_count,
  output logic              o_cross_sat
);
  typedef enum logic {ARM, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic              r_level, w_level_nxt;
  logic [WIN_W-1:0]  r_win, w_win_nxt;
  logic [CNT_W-1:0]  r_cross, w_cross_nxt;
  logic              r_sat, w_sat_nxt;
  logic              r_bit_out, w_bit_nxt;
  logic              r_bit_valid, w_bv_nxt;
  logic [CNT_W-1:0]  r_cross_count, w_cc_nxt;
  logic              r_cross_sat, w_cs_nxt;
  logic [DATA_W:0]   w_upper_ext, w_lower_ext;
  logic [DATA_W-1:0] w_upper, w_lower;
  logic [WIN_W-1:0]  w_win_max, w_win_base, w_win_inc;
  logic [CNT_W-1:0]  w_cross_base, w_cross_tot;
  logic              w_sat_base, w_sat_tot;
  logic              w_clr, w_up, w_dn, w_evt, w_at_max, w_close;
  // Thresholds use one extra bit so the sum/difference can be clamped instead of wrapping.
  assign w_upper_ext  = {1'b0, i_cfg_center} + {1'b0, i_cfg_hyst};
  assign w_lower_ext  = {1'b0, i_cfg_center} - {1'b0, i_cfg_hyst};
  assign w_upper      = w_upper_ext[DATA_W] ? '1 : w_upper_ext[DATA_W-1:0];
  assign w_lower      = w_lower_ext[DATA_W] ? '0 : w_lower_ext[DATA_W-1:0];
  assign w_win_max    = (i_cfg_window == '0) ? WIN_W'(1) : i_cfg_window;
  assign w_clr        = (r_state == RUN) && i_sync;
  assign w_win_base   = w_clr ? '0 : r_win;
  assign w_cross_base = w_clr ? '0 : r_cross;
  assign w_sat_base   = w_clr ? 1'b0 : r_sat;
  assign w_up         = (r_state == RUN) && !r_level && (i_sample_in > w_upper);
  assign w_dn         = (r_state == RUN) && r_level && (i_sample_in < w_lower);
  assign w_evt        = w_up || w_dn;
  assign w_at_max     = (w_cross_base == '1);
  assign w_cross_tot  = w_cross_base + CNT_W'(w_evt && !w_at_max);
  assign w_sat_tot    = w_sat_base || (w_evt && w_at_max);
  assign w_win_inc    = w_win_base + WIN_W'(1);
  // >= rather than == so a window shrunk below the current count closes on the next sample.
  assign w_close      = (w_win_inc >= w_win_max);
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_win_nxt   = w_win_base;
    w_cross_nxt = w_cross_base;
    w_sat_nxt   = w_sat_base;
    w_bit_nxt   = r_bit_out;
    w_bv_nxt    = 1'b0;
    w_cc_nxt    = r_cross_count;
    w_cs_nxt    = r_cross_sat;
    if (i_sample_valid) begin
      w_state_nxt = RUN;
      w_level_nxt = (r_state == ARM) ? (i_sample_in >= i_cfg_center) : (w_up || (r_level && !w_dn));
      w_win_nxt   = w_close ? '0 : w_win_inc;
      w_cross_nxt = w_close ? '0 : w_cross_tot;
      w_sat_nxt   = w_close ? 1'b0 : w_sat_tot;
      w_bv_nxt    = w_close;
      w_bit_nxt   = w_close ? (w_cross_tot >= i_cfg_decide) : r_bit_out;
      w_cc_nxt    = w_close ? w_cross_tot : r_cross_count;
      w_cs_nxt    = w_close ? w_sat_tot : r_cross_sat;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ARM;
      r_level       <= 1'b0;
      r_win         <= '0;
      r_cross       <= '0;
      r_sat         <= 1'b0;
      r_bit_out     <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_cross_count <= '0;
      r_cross_sat   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_level       <= w_level_nxt;
      r_win         <= w_win_nxt;
      r_cross       <= w_cross_nxt;
      r_sat         <= w_sat_nxt;
      r_bit_out     <= w_bit_nxt;
      r_bit_valid   <= w_bv_nxt;
      r_cross_count <= w_cc_nxt;
      r_cross_sat   <= w_cs_nxt;
    end
  end
  assign o_bit_out     = r_bit_out;
  assign o_bit_valid   = r_bit_valid;
  assign o_cross_count = r_cross_count;
  assign o_cross_sat   = r_cross_sat;
endmodule

// File: tb/tb_fsk_zc_demod.sv
// tb_fsk_zc_demod: directed, table-driven checks of the zero-crossing FSK demodulator.
module tb_fsk_zc_demod;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] sample = '0;
  logic valid = 1'b0, sync_i = 1'b0;
  logic [7:0] center = 8'd128, hyst = 8'd8, decide = 8'd6;
  logic [15:0] window = 16'd16;
  logic bit_out, bit_valid, cross_sat, b4_out, b4_valid, c4_sat;
  logic [7:0] cross_count;
  logic [3:0] c4_count;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  fsk_zc_demod u8 (
    .clk(clk), .rst_n(rst_n), .i_sample_in(sample), .i_sample_valid(valid),
    .i_cfg_center(center), .i_cfg_hyst(hyst), .i_cfg_window(window), .i_cfg_decide(decide),
    .i_sync(sync_i), .o_bit_out(bit_out), .o_bit_valid(bit_valid),
    .o_cross_count(cross_count), .o_cross_sat(cross_sat)
  );

  fsk_zc_demod #(.DATA_W(8), .WIN_W(16), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .i_sample_in(sample), .i_sample_valid(valid),
    .i_cfg_center(center), .i_cfg_hyst(hyst), .i_cfg_window(window), .i_cfg_decide(decide[3:0]),
    .i_sync(sync_i), .o_bit_out(b4_out), .o_bit_valid(b4_valid),
    .o_cross_count(c4_count), .o_cross_sat(c4_sat)
  );

  typedef struct {
    int center, hyst, window, decide, pat, nwin;
    int c1, b1, s1, cs, bs, ss;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_s(input int p, input int k);
    case (p)
      0: return (k % 4 < 2) ? 8'd200 : 8'd50;
      1: return (k % 8 < 4) ? 8'd200 : 8'd50;
      2: return (k % 2 == 1) ? 8'd131 : 8'd125;
      3: return (k % 2 == 1) ? 8'd255 : 8'd0;
      4: return (k % 2 == 1) ? 8'd120 : 8'd136;
      default: return 8'd0;
    endcase
  endfunction

  task automatic step(input logic [7:0] s, input logic v, input logic sy);
    sample = s;
    valid = v;
    sync_i = sy;
    @(posedge clk);
    #1;
    valid = 1'b0;
    sync_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_pat(input int p, input int nwin, input int win, input bit gap,
                         input int c1, input int b1, input int s1,
                         input int cs, input int bs, input int ss, input bit sel4);
    int k, cyc, w;
    bit v;
    k = 0; cyc = 0; w = 0;
    while (k < nwin * win) begin
      v = !(gap && (cyc % 3 == 2));
      step(pat_s(p, k), v, 1'b0);
      cyc++;
      if (v) k++;
      if (v && (k % win == 0)) begin
        chk($sformatf("p%0d w%0d strobe", p, w), int'(sel4 ? b4_valid : bit_valid), 1);
        chk($sformatf("p%0d w%0d count", p, w), int'(sel4 ? {4'd0, c4_count} : cross_count), (w == 0) ? c1 : cs);
        chk($sformatf("p%0d w%0d bit", p, w), int'(sel4 ? b4_out : bit_out), (w == 0) ? b1 : bs);
        chk($sformatf("p%0d w%0d sat", p, w), int'(sel4 ? c4_sat : cross_sat), (w == 0) ? s1 : ss);
        w++;
      end else if (sel4 ? b4_valid : bit_valid) begin
        chk($sformatf("p%0d spurious strobe k%0d", p, k), 1, 0);
      end
    end
  endtask

  initial begin
    vec_t vt[9];
    int exp_c[4];
    vt[0] = '{128, 8, 16, 6, 0, 3, 7, 1, 0, 8, 1, 0};
    vt[1] = '{128, 8, 16, 8, 0, 3, 7, 0, 0, 8, 1, 0};
    vt[2] = '{128, 8, 16, 6, 1, 3, 3, 0, 0, 4, 0, 0};
    vt[3] = '{128, 8, 16, 6, 2, 2, 0, 0, 0, 0, 0, 0};
    vt[4] = '{128, 8, 16, 0, 2, 2, 0, 1, 0, 0, 1, 0};
    vt[5] = '{128, 8, 16, 6, 4, 2, 0, 0, 0, 0, 0, 0};
    vt[6] = '{128, 8, 16, 6, 3, 2, 15, 1, 0, 16, 1, 0};
    vt[7] = '{250, 20, 16, 6, 3, 2, 0, 0, 0, 0, 0, 0};
    vt[8] = '{10, 20, 16, 6, 3, 2, 1, 0, 0, 0, 0, 0};

    do_reset();
    chk("reset bit_out", int'(bit_out), 0);
    chk("reset bit_valid", int'(bit_valid), 0);
    chk("reset cross_count", int'(cross_count), 0);
    chk("reset cross_sat", int'(cross_sat), 0);

    for (int i = 0; i < 9; i++) begin
      center = 8'(vt[i].center);
      hyst = 8'(vt[i].hyst);
      window = 16'(vt[i].window);
      decide = 8'(vt[i].decide);
      do_reset();
      run_pat(vt[i].pat, vt[i].nwin, vt[i].window, 1'b0,
              vt[i].c1, vt[i].b1, vt[i].s1, vt[i].cs, vt[i].bs, vt[i].ss, 1'b0);
    end

    center = 8'd128; hyst = 8'd8; window = 16'd16; decide = 8'd6;
    do_reset();
    run_pat(0, 3, 16, 1'b1, 7, 1, 0, 8, 1, 0, 1'b0);

    do_reset();
    for (int k = 0; k < 8; k++) step(pat_s(0, k), 1'b1, 1'b0);
    step(pat_s(0, 8), 1'b1, 1'b1);
    for (int k = 9; k < 23; k++) begin
      step(pat_s(0, k), 1'b1, 1'b0);
      if (k == 15 || bit_valid) chk($sformatf("sync no strobe k%0d", k), int'(bit_valid), 0);
    end
    step(pat_s(0, 23), 1'b1, 1'b0);
    chk("sync strobe", int'(bit_valid), 1);
    chk("sync count", int'(cross_count), 8);
    chk("sync bit", int'(bit_out), 1);

    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(pat_s(1, k), 1'b1, 1'b0);
      if (k == 15) chk("low tone w0 count", int'(cross_count), 3);
    end
    for (int j = 0; j < 16; j++) begin
      step(pat_s(0, j), 1'b1, j == 0);
      if (j == 15) begin
        chk("tone switch strobe", int'(bit_valid), 1);
        chk("tone switch count", int'(cross_count), 7);
        chk("tone switch bit", int'(bit_out), 1);
      end else if (bit_valid) chk($sformatf("tone switch spurious j%0d", j), 1, 0);
    end

    center = 8'd128; hyst = 8'd8; window = 16'd40; decide = 8'd6;
    do_reset();
    run_pat(3, 2, 40, 1'b0, 15, 1, 1, 15, 1, 1, 1'b1);
    center = 8'd250; hyst = 8'd20;
    do_reset();
    run_pat(3, 1, 40, 1'b0, 0, 0, 0, 0, 0, 0, 1'b1);

    center = 8'd128; hyst = 8'd8; window = 16'd0; decide = 8'd1;
    exp_c = '{0, 0, 1, 0};
    do_reset();
    for (int j = 0; j < 4; j++) begin
      step(pat_s(0, j), 1'b1, 1'b0);
      chk($sformatf("win0 strobe %0d", j), int'(bit_valid), 1);
      chk($sformatf("win0 count %0d", j), int'(cross_count), exp_c[j]);
      chk($sformatf("win0 bit %0d", j), int'(bit_out), exp_c[j]);
    end
    step(8'd200, 1'b0, 1'b0);
    chk("win0 idle no strobe", int'(bit_valid), 0);

    window = 16'd16; decide = 8'd6;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      step(pat_s(0, k), 1'b1, 1'b0);
      if (k == 15) chk("pre-reset count", int'(cross_count), 7);
    end
    chk("held bit_out", int'(bit_out), 1);
    chk("held cross_count", int'(cross_count), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset bit_out", int'(bit_out), 0);
    chk("async reset cross_count", int'(cross_count), 0);
    chk("async reset bit_valid", int'(bit_valid), 0);
    chk("async reset cross_sat", int'(cross_sat), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int j = 0; j < 16; j++) begin
      step(pat_s(0, j), 1'b1, 1'b0);
      if (j == 15) begin
        chk("rearm strobe", int'(bit_valid), 1);
        chk("rearm count", int'(cross_count), 7);
      end else if (bit_valid) chk($sformatf("rearm spurious j%0d", j), 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
